// File: rtl/mem_pkg.sv
// Shared types and constants for the line responder: bus widths, default
// parameters, engine FSM states and the queued request entry.
package mem_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned LINE_W = 128;

  localparam int unsigned DEF_LATENCY     = 5;
  localparam int unsigned DEF_QUEUE_DEPTH = 4;
  localparam int unsigned DEF_LINE_COUNT  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } rqst_entry_t;

endpackage

// File: rtl/mem_line_responder_if.sv
// Request/response bus of the line responder; the requester is the master,
// the responder the slave.
interface mem_line_responder_if;
  import mem_pkg::*;

  logic              rqst_i;
  logic              rqst_we_i;
  logic [ADDR_W-1:0] rqst_addr_i;
  logic [LINE_W-1:0] rqst_data_i;
  logic              busy_o;
  logic              data_ready_o;
  logic [LINE_W-1:0] data_o;
  logic [ADDR_W-1:0] addr_o;

  modport slave (
    input  rqst_i, rqst_we_i, rqst_addr_i, rqst_data_i,
    output busy_o, data_ready_o, data_o, addr_o
  );

  modport master (
    output rqst_i, rqst_we_i, rqst_addr_i, rqst_data_i,
    input  busy_o, data_ready_o, data_o, addr_o
  );

endinterface

// File: rtl/mem_rqst_fifo.sv
// Pending-request queue with registered occupancy flags. When empty, a push
// and pop in the same cycle pass the entry straight through.
module mem_rqst_fifo
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_push,
  input  rqst_entry_t i_wr_data,
  input  logic        i_pop,
  output rqst_entry_t o_rd_data_c,
  output logic        o_full,
  output logic        o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rqst_entry_t      r_buf [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_through;
  logic             w_wr_en;
  logic             w_rd_en;

  // Pass-through entries never touch storage or pointers.
  always_comb begin
    w_do_push   = i_push & ~r_full;
    w_do_pop    = i_pop & (~r_empty | w_do_push);
    w_through   = r_empty & w_do_push & w_do_pop;
    w_wr_en     = w_do_push & ~w_through;
    w_rd_en     = w_do_pop & ~w_through;
    w_count_nxt = r_count + CNT_W'(w_wr_en) - CNT_W'(w_rd_en);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_buf[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data_c = r_empty ? i_wr_data : r_buf[r_rd_ptr];
  assign o_full      = r_full;
  assign o_empty     = r_empty;

endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency 128-bit line store: queued line writes and fills are served in
// order by an IDLE/ACCESS/DONE engine; reads answer with a one-cycle strobe.
module mem_line_responder
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY     = DEF_LATENCY,
  parameter int unsigned QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter int unsigned LINE_COUNT  = DEF_LINE_COUNT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mem_line_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(LINE_COUNT);
  localparam int unsigned CNT_W = 4;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  rqst_entry_t       r_cur;
  rqst_entry_t       w_in_entry;
  rqst_entry_t       w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_head_avail;
  logic              w_rsp_nxt;
  logic              w_mem_we;
  logic              r_data_ready;
  logic [LINE_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_mem [LINE_COUNT];
  logic [IDX_W-1:0]  w_idx;

  assign w_in_entry   = {bus.rqst_we_i, bus.rqst_addr_i, bus.rqst_data_i};
  assign w_push       = bus.rqst_i & ~w_fifo_full & ~rst_i;
  assign w_head_avail = ~w_fifo_empty | w_push;
  assign w_idx        = r_cur.addr[IDX_W+3:4];

  mem_rqst_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_push      (w_push),
    .i_wr_data   (w_in_entry),
    .i_pop       (w_pop),
    .o_rd_data_c (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // ACCESS spans LATENCY-1 cycles so DONE lands exactly LATENCY after a pop.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_rsp_nxt   = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_head_avail) begin
          w_pop       = 1'b1;
          w_cnt_nxt   = CNT_W'(LATENCY - 2);
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
          w_rsp_nxt   = ~r_cur.we;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_mem_we = r_cur.we & ~rst_i;
        if (w_head_avail) begin
          w_pop       = 1'b1;
          w_cnt_nxt   = CNT_W'(LATENCY - 2);
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_cur        <= '0;
      r_data_ready <= 1'b0;
      r_data       <= '0;
      r_addr       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_data_ready <= w_rsp_nxt;
      if (w_pop) r_cur <= w_head;
      if (w_rsp_nxt) begin
        r_data <= r_mem[w_idx];
        r_addr <= r_cur.addr;
      end
    end
  end

  // Line storage keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[w_idx] <= r_cur.data;
  end

  assign bus.busy_o       = w_fifo_full;
  assign bus.data_ready_o = r_data_ready;
  assign bus.data_o       = r_data;
  assign bus.addr_o       = r_addr;

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: directed requests push expected
// read responses; a negedge monitor checks strobe timing, data, address, hold.
module tb_mem_line_responder;
  import mem_pkg::*;

  localparam int unsigned LAT = 5;

  typedef struct {
    logic [LINE_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_line_responder_if bus();

  mem_line_responder #(
    .LATENCY     (LAT),
    .QUEUE_DEPTH (4),
    .LINE_COUNT  (1024)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  exp_t              sb[$];
  exp_t              mon_e;
  int                cyc       = 0;
  int                last_done = 0;
  int                n_checks  = 0;
  int                n_pass    = 0;
  logic [LINE_W-1:0] hold_data = '0;
  logic [ADDR_W-1:0] hold_addr = '0;

  localparam logic [LINE_W-1:0] D1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [LINE_W-1:0] DA = 128'haaaa_0000_1111_2222_3333_4444_5555_aaaa;
  localparam logic [LINE_W-1:0] DB = 128'hbbbb_9999_8888_7777_6666_5555_4444_bbbb;
  localparam logic [LINE_W-1:0] DC = 128'hc0de_c0de_0000_0001_dead_beef_0bad_f00d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // For reads, d is the expected line; for writes, the line written.
  task automatic issue(input logic we, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] d, input logic exp_busy);
    int start;
    @(posedge clk); #1;
    bus.rqst_i      = 1'b1;
    bus.rqst_we_i   = we;
    bus.rqst_addr_i = a;
    bus.rqst_data_i = we ? d : ~d;
    chk("busy_at_issue", LINE_W'(bus.busy_o), LINE_W'(exp_busy));
    if (!exp_busy) begin
      start     = (cyc > last_done) ? cyc : last_done;
      last_done = start + int'(LAT);
      if (!we) sb.push_back('{data: d, addr: a, cyc: last_done});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.rqst_i = 1'b0;
    end
  endtask

  // A write to line 3 is presented during reset; it must not land.
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst             = 1'b1;
    bus.rqst_i      = 1'b1;
    bus.rqst_we_i   = 1'b1;
    bus.rqst_addr_i = 20'h00030;
    bus.rqst_data_i = '1;
    sb.delete();
    last_done = 0;
    hold_data = '0;
    hold_addr = '0;
    repeat (n - 1) @(posedge clk);
    @(posedge clk); #1;
    rst        = 1'b0;
    bus.rqst_i = 1'b0;
    chk("rst_busy",       LINE_W'(bus.busy_o),       '0);
    chk("rst_data_ready", LINE_W'(bus.data_ready_o), '0);
    chk("rst_data",       bus.data_o,                '0);
    chk("rst_addr",       LINE_W'(bus.addr_o),       '0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.data_ready_o) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp", LINE_W'(bus.data_ready_o), '0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_data",  bus.data_o,             mon_e.data);
          chk("rsp_addr",  LINE_W'(bus.addr_o),    LINE_W'(mon_e.addr));
          chk("rsp_cycle", LINE_W'(cyc),           LINE_W'(mon_e.cyc));
          hold_data = mon_e.data;
          hold_addr = mon_e.addr;
        end
      end else begin
        chk("hold_data", bus.data_o,          hold_data);
        chk("hold_addr", LINE_W'(bus.addr_o), LINE_W'(hold_addr));
      end
    end
  end

  initial begin
    int k;
    bus.rqst_i      = 1'b0;
    bus.rqst_we_i   = 1'b0;
    bus.rqst_addr_i = '0;
    bus.rqst_data_i = '0;
    do_reset(2);

    // Preload line 3, then read it back through a different byte offset.
    issue(1'b1, 20'h00030, D1, 1'b0);
    idle(6);
    issue(1'b0, 20'h00034, D1, 1'b0);
    idle(8);

    // Fill lines 0x50..0x54 back-to-back, then six reads: the sixth hits busy.
    for (int i = 0; i < 5; i++)
      issue(1'b1, ADDR_W'(32'h00500 + 32'(i) * 16), {32'(i), 32'h5eed_0000, 32'(i * 7), 32'hf00d}, 1'b0);
    idle(25);
    for (int i = 0; i < 5; i++)
      issue(1'b0, ADDR_W'(32'h00500 + 32'(i) * 16), {32'(i), 32'h5eed_0000, 32'(i * 7), 32'hf00d}, 1'b0);
    issue(1'b0, 20'h00550, '0, 1'b1);
    idle(1);
    chk("busy_release", LINE_W'(bus.busy_o), '0);
    idle(25);

    // Same-line write/read/write/read ordering.
    issue(1'b1, 20'h00100, DA, 1'b0);
    issue(1'b0, 20'h00100, DA, 1'b0);
    issue(1'b1, 20'h00100, DB, 1'b0);
    issue(1'b0, 20'h00100, DB, 1'b0);
    idle(25);

    // High address bits alias onto line 1.
    issue(1'b1, 20'h04010, DC, 1'b0);
    issue(1'b0, 20'h00010, DC, 1'b0);
    idle(14);

    // Reset two cycles into an access; the line must survive.
    issue(1'b0, 20'h00034, D1, 1'b0);
    idle(1);
    do_reset(1);
    issue(1'b0, 20'h00034, D1, 1'b0);
    idle(1);

    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("drain_empty", LINE_W'(sb.size()), '0);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
